// File: rtl/mac_tile_ws_if.sv
// Bus bundle for one weight-stationary MAC tile: west/north inputs, east/south outputs.
interface mac_tile_ws_if #(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned ch      = 2,
  parameter int unsigned cnt_bw  = 16
);
  logic [ch*bw-1:0]          in_w;
  logic signed [psum_bw-1:0] in_n;
  logic [1:0]                inst_w;
  logic                      w_clear;
  logic [ch*bw-1:0]          out_e;
  logic [1:0]                inst_e;
  logic signed [psum_bw-1:0] out_s;
  logic                      valid_s;
  logic                      loaded;
  logic [cnt_bw-1:0]         gated_cnt;

  // Driver side: the upstream tile or the bench.
  modport master (
    output in_w, in_n, inst_w, w_clear,
    input  out_e, inst_e, out_s, valid_s, loaded, gated_cnt
  );

  // Tile side.
  modport slave (
    input  in_w, in_n, inst_w, w_clear,
    output out_e, inst_e, out_s, valid_s, loaded, gated_cnt
  );
endinterface

// File: rtl/mac_tile_ws.sv
// Weight-stationary multi-channel MAC tile: unsigned activations x held signed weights,
// plus north partial sum, registered south; activations/instructions registered east.
// Optional build macro MAC_TILE_GATE_EN: zero-weight operand gating and gated-op counter.
module mac_tile_ws #(
  parameter int unsigned bw      = 4,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned ch      = 2,
  parameter int unsigned cnt_bw  = 16
) (
  input  logic         clk,
  input  logic         reset,
  mac_tile_ws_if.slave bus
);

  localparam int unsigned PW = 2 * bw + 1;

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_LOADED = 1'b1;

  logic [0:0]                state_q, state_d;
  logic                      capture_c;
  logic [ch*bw-1:0]          w_q;
  logic signed [psum_bw-1:0] sum_c;
  logic [ch*bw-1:0]          out_e_q;
  logic [1:0]                inst_e_q;
  logic signed [psum_bw-1:0] out_s_q;
  logic                      valid_s_q;

`ifdef MAC_TILE_GATE_EN
  logic [ch-1:0]     mask_q;
  logic [ch-1:0]     mask_d;
  logic [cnt_bw-1:0] cnt_q;
  logic [cnt_bw:0]   cnt_sum_c;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next state: clear wins over load; a load in LOADED is only forwarded east.
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    if (bus.w_clear) begin
      state_d = ST_EMPTY;
    end else if (state_q == ST_EMPTY && bus.inst_w[0]) begin
      state_d   = ST_LOADED;
      capture_c = 1'b1;
    end
  end

  // Held weights; zeroed by reset or clear.
  always_ff @(posedge clk) begin
    if (!reset || bus.w_clear) w_q <= '0;
    else if (capture_c)        w_q <= bus.in_w;
  end

`ifdef MAC_TILE_GATE_EN
  // Non-zero mask computed from the word being captured.
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < int'(ch); i++) mask_d[i] = |bus.in_w[i*bw +: bw];
  end

  // Channel mask register, tracks w_q.
  always_ff @(posedge clk) begin
    if (!reset || bus.w_clear) mask_q <= '0;
    else if (capture_c)        mask_q <= mask_d;
  end

  // Saturating sum of the current count and the number of masked channels.
  always_comb begin
    cnt_sum_c = {1'b0, cnt_q};
    for (int i = 0; i < int'(ch); i++) cnt_sum_c = cnt_sum_c + (cnt_bw+1)'(!mask_q[i]);
    if (cnt_sum_c[cnt_bw]) cnt_sum_c = {1'b0, {cnt_bw{1'b1}}};
  end

  // Gated-operation counter; survives w_clear, counts only executes in LOADED.
  always_ff @(posedge clk) begin
    if (!reset)                                     cnt_q <= '0;
    else if (bus.inst_w[1] && state_q == ST_LOADED) cnt_q <= cnt_sum_c[cnt_bw-1:0];
  end

  assign bus.gated_cnt = cnt_q;
`else
  assign bus.gated_cnt = '0;
`endif

  // Dot product of zero-extended activations and sign-extended weights.
  always_comb begin
    logic signed [PW-1:0] a_op;
    logic signed [PW-1:0] b_op;
    logic signed [PW-1:0] prod;
    sum_c = '0;
    for (int i = 0; i < int'(ch); i++) begin
      a_op = PW'(bus.in_w[i*bw +: bw]);
      b_op = PW'(signed'(w_q[i*bw +: bw]));
`ifdef MAC_TILE_GATE_EN
      if (!mask_q[i]) begin
        a_op = '0;
        b_op = '0;
      end
`endif
      prod  = a_op * b_op;
      sum_c = sum_c + psum_bw'(prod);
    end
  end

  // East forwarding and south result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_e_q   <= '0;
      inst_e_q  <= '0;
      out_s_q   <= '0;
      valid_s_q <= 1'b0;
    end else begin
      out_e_q   <= bus.in_w;
      inst_e_q  <= bus.inst_w;
      valid_s_q <= bus.inst_w[1];
      if (bus.inst_w[1]) out_s_q <= bus.in_n + sum_c;
    end
  end

  assign bus.out_e   = out_e_q;
  assign bus.inst_e  = inst_e_q;
  assign bus.out_s   = out_s_q;
  assign bus.valid_s = valid_s_q;
  assign bus.loaded  = (state_q == ST_LOADED);

endmodule

// File: doc/mac_tile_ws.md
# mac_tile_ws

Weight-stationary, multi-channel processing-element tile for the systolic MAC array: holds one signed weight per input channel, multiplies the unsigned activations streamed from the west by those weights, and adds the partial sum arriving from the north. It registers the result southward, and registers activations and instructions eastward. It is the sequential, parametrised successor to the combinational zero-weight-gated `mac` datapath, and the array generator instantiates it once per row/column position.

## Interface

- `bw`, 4, activation/weight bit width per channel
- `psum_bw`, 16, partial-sum width
- `ch`, 2, input channels per tile (≥1)
- `cnt_bw`, 16, gated-operation counter width

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `in_w`  in  ch*bw  activations (execute) or weights (load), channel i at `[i*bw +: bw]`
- `in_n`  in  psum_bw  signed partial sum from north
- `inst_w`  in  2  `[0]` kernel load, `[1]` execute
- `w_clear`  in  1  discard held weights, return to EMPTY
- `out_e`  out  ch*bw  registered `in_w` to east
- `inst_e`  out  2  registered `inst_w` to east
- `out_s`  out  psum_bw  registered signed partial sum to south
- `valid_s`  out  1  `out_s` holds a new result this cycle
- `loaded`  out  1  high in state LOADED
- `gated_cnt`  out  cnt_bw  count of gated channel-operations

## Operation

- FSM states:
  - EMPTY (reset state): `w_q` = 0, `mask_q` = 0.
  - LOADED: weights held.
- Transitions:
  - EMPTY + `inst_w[0]`: capture `in_w` into `w_q`; `mask_q[i]` = (`w_q[i]` != 0) evaluated on the captured weight; go to LOADED.
  - LOADED + `inst_w[0]`: no capture; the word is only forwarded east, so the next tile loads it.
  - `w_clear` in any state: go to EMPTY and zero `w_q`/`mask_q`. It has priority over a same-cycle load.
- Execute (`inst_w[1]`):
  - Per channel: `a_i` = {1'b0, `in_w[i]`}, i.e. (bw+1)-bit non-negative; `b_i` = signed bw-bit `w_q[i]`; product is 2bw+1 bits signed.
  - Sum of the `ch` products is sign-extended to `psum_bw`. `out_s` ← `in_n` + sum, two's-complement wrap modulo 2^psum_bw, no saturation.
  - Execute in EMPTY: all weights are 0, so `out_s` ← `in_n`.
  - Load+execute in EMPTY: execute uses the old (zero) weights, and the capture completes at the same edge.
  - Load+execute in LOADED: execute with the held weights.
- No execute: `out_s` holds its value; `valid_s` ← 0.
- Forwarding: `out_e` ← `in_w` and `inst_e` ← `inst_w` every cycle, regardless of state.
- Reset values (on `reset`=0 at an edge):
  - all outputs 0;
  - state EMPTY;
  - `w_q`, `mask_q`, `gated_cnt` = 0.
  - Reset mid-stream discards weights and any pending result.

## Timing

- One-cycle latency on every path. Inputs sampled at edge t appear on `out_e`/`inst_e`/`out_s`/`valid_s` after edge t, for use in cycle t+1.
- `loaded` rises the cycle after the load edge.
- `valid_s` is a single-cycle pulse per execute. Back-to-back executes give `valid_s` continuously high with a new `out_s` each cycle.
- No backpressure: the downstream tile must sample every cycle.

## Configuration

- `MAC_TILE_GATE_EN` defined:
  - Each channel with `mask_q[i]` = 0 has both multiplier operands forced to 0 (toggle suppression).
  - Every execute in LOADED adds the number of masked channels to `gated_cnt`, which saturates at all-ones.
  - `w_clear` does not reset `gated_cnt`.
- Undefined:
  - No operand masking; `gated_cnt` is tied to 0.
- Arithmetic results are identical in both builds.

## Test plan

- Load and compute:
  - Stimulus (bw=4, ch=2): load `in_w`=8'hF3, i.e. w0=3, w1=−1; then execute `in_w`=8'h25, `in_n`=10.
  - Required: `out_s`=23 with `valid_s`=1 exactly one cycle later; `loaded`=1; `out_e`=8'h25.
- Second load ignored:
  - Stimulus: after the above, `inst_w`=01 with `in_w`=8'h11, then execute `in_w`=8'h25, `in_n`=10.
  - Required: `out_s`=23 again; `out_e`=8'h11 and `inst_e`=01 the cycle after the load.
- Zero-weight gating:
  - Stimulus: load 8'h40 (w0=0, w1=4); three executes with `in_w`=8'h77, `in_n`=0.
  - Required: `out_s`=28 each time; `gated_cnt`=3 with `MAC_TILE_GATE_EN`, 0 without.
- Wrap-around:
  - Stimulus: weights w0=7, w1=0; execute `in_w`=8'h0F, `in_n`=16'h7FFF.
  - Required: `out_s`=16'h8068.
- EMPTY and clear:
  - Stimulus: execute before any load with `in_n`=−5; then load, assert `w_clear`, execute with `in_n`=9.
  - Required: `out_s`=−5; `loaded`=0 after the clear; `out_s`=9.
- Reset mid-operation:
  - Stimulus: pulse `reset`=0 for one cycle during back-to-back executes.
  - Required: the next cycle shows all outputs 0, `loaded`=0 and `gated_cnt`=0; a subsequent execute returns `in_n`.
